// File: rtl/bird_plotter.sv
// Pixel sequencer for one bird sprite: erases the previously drawn sprite,
// then draws it at the new anchor, one registered pixel per clock.
module bird_plotter #(
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         X_MAX     = 159,
    parameter int         Y_MAX     = 119
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       hide,
    input  logic [7:0] bird_x,
    input  logic [6:0] bird_y,
    input  logic       wing_up,
    input  logic [2:0] colour_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

    localparam logic [7:0] X_LIM = 8'(X_MAX);
    localparam logic [6:0] Y_LIM = 7'(Y_MAX);

    state_t      state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [7:0]  lat_x_q, lat_x_d, old_x_q, old_x_d;
    logic [6:0]  lat_y_q, lat_y_d, old_y_q, old_y_d;
    logic        lat_wing_q, lat_wing_d, old_wing_q, old_wing_d;
    logic [2:0]  lat_col_q, lat_col_d;
    logic        lat_hide_q, lat_hide_d;
    logic        valid_q, valid_d;
    logic [7:0]  vga_x_q, vga_x_d;
    logic [6:0]  vga_y_q, vga_y_d;
    logic [2:0]  vga_col_q, vga_col_d;
    logic        vga_plot_q, vga_plot_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        lat_x_d    = lat_x_q;
        lat_y_d    = lat_y_q;
        lat_wing_d = lat_wing_q;
        lat_col_d  = lat_col_q;
        lat_hide_d = lat_hide_q;
        old_x_d    = old_x_q;
        old_y_d    = old_y_q;
        old_wing_d = old_wing_q;
        valid_d    = valid_q;
        case (state_q)
            // FINISH accepts a start exactly like IDLE so requests can run back to back.
            IDLE, FINISH: begin
                state_d = IDLE;
                if (start) begin
                    lat_x_d    = bird_x;
                    lat_y_d    = bird_y;
                    lat_wing_d = wing_up;
                    lat_col_d  = colour_in;
                    lat_hide_d = hide;
                    k_d        = 4'd0;
                    if (valid_q) begin
                        state_d = ERASE;
                    end else if (hide) begin
                        state_d = FINISH;
                        valid_d = 1'b0;
                    end else begin
                        state_d = DRAW;
                    end
                end
            end
            ERASE: begin
                if (k_q == 4'd9) begin
                    k_d = 4'd0;
                    if (lat_hide_q) begin
                        state_d = FINISH;
                        valid_d = 1'b0;
                    end else begin
                        state_d = DRAW;
                    end
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            DRAW: begin
                if (k_q == 4'd9) begin
                    k_d        = 4'd0;
                    state_d    = FINISH;
                    old_x_d    = lat_x_q;
                    old_y_d    = lat_y_q;
                    old_wing_d = lat_wing_q;
                    valid_d    = 1'b1;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel for the cycle being entered is computed from next-state values so outputs stay registered.
    logic              active;
    logic [7:0]        anc_x;
    logic [6:0]        anc_y;
    logic              anc_wing;
    logic [2:0]        pix_col;
    logic signed [8:0] dx, sum_x;
    logic signed [7:0] dy, sum_y;
    logic              on_screen;

    always_comb begin
        active   = (state_d == ERASE) || (state_d == DRAW);
        anc_x    = lat_x_d;
        anc_y    = lat_y_d;
        anc_wing = lat_wing_d;
        pix_col  = lat_col_d;
        if (state_d == ERASE) begin
            anc_x    = old_x_q;
            anc_y    = old_y_q;
            anc_wing = old_wing_q;
            pix_col  = BG_COLOUR;
        end
        dx = 9'sd0;
        dy = 8'sd0;
        case (k_d)
            4'd1: dx = -9'sd1;
            4'd2: dx = -9'sd2;
            4'd3: dx = -9'sd3;
            4'd4: dx = -9'sd4;
            4'd5: dx = -9'sd5;
            4'd6: begin dx = 9'sd1;  dy = -8'sd1; end
            4'd7: begin dx = -9'sd3; dy = anc_wing ? -8'sd1 : 8'sd1; end
            4'd8: begin dx = -9'sd4; dy = anc_wing ? -8'sd2 : 8'sd2; end
            4'd9: begin dx = -9'sd5; dy = anc_wing ? -8'sd3 : 8'sd3; end
            default: begin dx = 9'sd0; dy = 8'sd0; end
        endcase
        sum_x     = $signed({1'b0, anc_x}) + dx;
        sum_y     = $signed({1'b0, anc_y}) + dy;
        // Sign bit set means negative or wrapped past the top of the range; both are off-screen.
        on_screen = !sum_x[8] && (sum_x[7:0] <= X_LIM) && !sum_y[7] && (sum_y[6:0] <= Y_LIM);
        vga_x_d    = active ? sum_x[7:0] : 8'd0;
        vga_y_d    = active ? sum_y[6:0] : 7'd0;
        vga_col_d  = active ? pix_col : 3'd0;
        vga_plot_d = active && on_screen;
        busy_d     = active;
        done_d     = (state_d == FINISH);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            k_q        <= 4'd0;
            lat_x_q    <= 8'd0;
            lat_y_q    <= 7'd0;
            lat_wing_q <= 1'b0;
            lat_col_q  <= 3'd0;
            lat_hide_q <= 1'b0;
            old_x_q    <= 8'd0;
            old_y_q    <= 7'd0;
            old_wing_q <= 1'b0;
            valid_q    <= 1'b0;
            vga_x_q    <= 8'd0;
            vga_y_q    <= 7'd0;
            vga_col_q  <= 3'd0;
            vga_plot_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            lat_x_q    <= lat_x_d;
            lat_y_q    <= lat_y_d;
            lat_wing_q <= lat_wing_d;
            lat_col_q  <= lat_col_d;
            lat_hide_q <= lat_hide_d;
            old_x_q    <= old_x_d;
            old_y_q    <= old_y_d;
            old_wing_q <= old_wing_d;
            valid_q    <= valid_d;
            vga_x_q    <= vga_x_d;
            vga_y_q    <= vga_y_d;
            vga_col_q  <= vga_col_d;
            vga_plot_q <= vga_plot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_col_q;
    assign vga_plot   = vga_plot_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_bird_plotter.sv
// Bench for bird_plotter: a sprite-level model fills an expected per-cycle
// queue at each accepted start; one negedge process compares every cycle.
module tb_bird_plotter;
    logic       clock;
    logic       resetn;
    logic       start;
    logic       hide;
    logic [7:0] bird_x;
    logic [6:0] bird_y;
    logic       wing_up;
    logic [2:0] colour_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    bird_plotter dut (
        .clock(clock), .resetn(resetn), .start(start), .hide(hide),
        .bird_x(bird_x), .bird_y(bird_y), .wing_up(wing_up), .colour_in(colour_in),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .done(done)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Entry: {care_xy[21], x[20:13], y[12:6], colour[5:3], plot[2], busy[1], done[0]}
    logic [21:0] exp_q[$];
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int req_cyc = 0;
    int done_cyc = -1;
    int plot_cnt = 0;

    bit m_valid = 1'b0;
    int m_ox = 0, m_oy = 0;
    bit m_ow = 1'b0;

    int dx_tab[10]    = '{0, -1, -2, -3, -4, -5, 1, -3, -4, -5};
    int dy_up_tab[10] = '{0, 0, 0, 0, 0, 0, -1, -1, -2, -3};

    task automatic chk(string nm, int act, int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    endtask

    function automatic logic [21:0] pix(int ax, int ay, bit w, int k, int col, bit bsy);
        int px, py;
        bit vis;
        logic [7:0] xb;
        logic [6:0] yb;
        logic [2:0] cb;
        px  = ax + dx_tab[k];
        py  = ay + ((k >= 7 && !w) ? -dy_up_tab[k] : dy_up_tab[k]);
        vis = (px >= 0) && (px <= 159) && (py >= 0) && (py <= 119);
        xb  = px[7:0];
        yb  = py[6:0];
        cb  = col[2:0];
        return {vis, xb, yb, cb, vis, bsy, 1'b0};
    endfunction

    // Sprite-level model of one accepted request
    task automatic model_req(int x, int y, bit w, int c, bit h);
        if (m_valid)
            for (int k = 0; k < 10; k++) exp_q.push_back(pix(m_ox, m_oy, m_ow, k, 0, 1'b1));
        if (!h)
            for (int k = 0; k < 10; k++) exp_q.push_back(pix(x, y, w, k, c, 1'b1));
        exp_q.push_back(22'b1);
        if (h) begin
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b1;
            m_ox = x;
            m_oy = y;
            m_ow = w;
        end
    endtask

    // Compare process: one expected entry per cycle, otherwise the block must be quiet
    always @(negedge clock) begin
        logic [21:0] e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("plot", vga_plot, e[2]);
            chk("busy", busy, e[1]);
            chk("done", done, e[0]);
            if (e[21]) begin
                chk("vga_x", vga_x, e[20:13]);
                chk("vga_y", vga_y, e[12:6]);
                chk("colour", vga_colour, e[5:3]);
            end
        end else begin
            chk("idle_plot", vga_plot, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end
        if (vga_plot) plot_cnt++;
        if (done) done_cyc = cyc;
    end

    // Driver tasks
    task automatic do_req(int x, int y, bit w, int c, bit h);
        @(negedge clock);
        bird_x    = 8'(x);
        bird_y    = 7'(y);
        wing_up   = w;
        colour_in = 3'(c);
        hide      = h;
        start     = 1'b1;
        @(posedge clock);
        req_cyc = cyc;
        model_req(x, y, w, c, h);
        #1;
        start     = 1'b0;
        bird_x    = 8'($urandom_range(0, 255));
        bird_y    = 7'($urandom_range(0, 127));
        wing_up   = 1'($urandom_range(0, 1));
        colour_in = 3'($urandom_range(0, 7));
        hide      = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(int leave);
        int n = 0;
        while (exp_q.size() > leave) begin
            if (n >= 200) begin
                chk("timeout", exp_q.size(), leave);
                exp_q.delete();
                break;
            end
            @(posedge clock);
            n++;
        end
    endtask

    task automatic chk_zero_outputs(string tag);
        chk({tag, "_x"}, vga_x, 0);
        chk({tag, "_y"}, vga_y, 0);
        chk({tag, "_colour"}, vga_colour, 0);
        chk({tag, "_plot"}, vga_plot, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    int t1x[10] = '{20, 19, 18, 17, 16, 15, 21, 17, 16, 15};
    int t1y[10] = '{30, 30, 30, 30, 30, 30, 29, 29, 28, 27};
    int t2x[4]  = '{22, 18, 17, 16};
    int t2y[4]  = '{29, 31, 32, 33};

    initial begin
        logic [21:0] e;
        int base;
        resetn = 1'b0; start = 1'b0; hide = 1'b0; bird_x = 8'd0; bird_y = 7'd0;
        wing_up = 1'b0; colour_in = 3'd0;
        repeat (3) @(negedge clock);
        chk_zero_outputs("reset");
        resetn = 1'b1;

        // First draw at (20,30), wing up; pin the model against hand values
        do_req(20, 30, 1, 6, 0);
        for (int k = 0; k < 10; k++) begin
            e = exp_q[k];
            chk("pin1_x", e[20:13], t1x[k]);
            chk("pin1_y", e[12:6], t1y[k]);
        end
        wait_done(0);
        chk("lat_first_draw", done_cyc - req_cyc, 11);

        // Full erase + draw at (21,30), wing down; next request issued in its done cycle
        do_req(21, 30, 0, 6, 0);
        for (int k = 0; k < 4; k++) begin
            e = exp_q[16 + k];
            chk("pin2_x", e[20:13], t2x[k]);
            chk("pin2_y", e[12:6], t2y[k]);
        end
        wait_done(1);

        // Hide (erase only), then clipped first draw at (2,1)
        do_req(0, 0, 0, 0, 1);
        wait_done(0);
        chk("lat_hide_valid", done_cyc - req_cyc, 11);
        base = plot_cnt;
        do_req(2, 1, 1, 5, 0);
        wait_done(0);
        chk("clip_plots", plot_cnt - base, 4);
        chk("lat_clip", done_cyc - req_cyc, 11);

        // Draw at (50,60), hide it, hide again with nothing drawn
        do_req(50, 60, 1, 3, 0);
        wait_done(0);
        chk("lat_full", done_cyc - req_cyc, 21);
        do_req(50, 60, 1, 3, 1);
        wait_done(0);
        chk("lat_hide", done_cyc - req_cyc, 11);
        base = plot_cnt;
        do_req(50, 60, 1, 3, 1);
        wait_done(0);
        chk("lat_hide_empty", done_cyc - req_cyc, 1);
        chk("hide_empty_plots", plot_cnt - base, 0);

        // Busy rejection: start with (90,90) during cycle 5 must be ignored
        do_req(70, 50, 0, 2, 0);
        wait_done(0);
        do_req(72, 50, 1, 2, 0);
        repeat (4) @(posedge clock);
        #1;
        bird_x = 8'd90; bird_y = 7'd90; hide = 1'b0; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(0);
        chk("lat_busy_reject", done_cyc - req_cyc, 21);
        do_req(74, 52, 0, 1, 0);
        wait_done(0);

        // Right and bottom edge clipping
        do_req(160, 119, 0, 5, 0);
        wait_done(0);

        // Async reset in cycle 13 of a full request
        do_req(10, 100, 1, 7, 0);
        repeat (12) @(posedge clock);
        #2 resetn = 1'b0;
        exp_q.delete();
        m_valid = 1'b0;
        #1 chk_zero_outputs("async");
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        do_req(40, 40, 1, 4, 0);
        wait_done(0);
        chk("lat_after_reset", done_cyc - req_cyc, 11);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
